// File: rtl/universal_shift_reg_ctrl.sv
// Universal shift register with a command FSM: parallel load, logical shifts,
// rotates and arithmetic shift right, each run for a programmable bit count.
module universal_shift_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_left,
  input  logic             sin_right,
  output logic [WIDTH-1:0] d_out,
  output logic             sout_left,
  output logic             sout_right,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;

  logic [1:0]       state;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] rem;
  logic             err_q;
  logic             accept;

  // One single-bit step; serial inputs only matter for the logical shifts.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       md,
    input logic             sl,
    input logic             sr
  );
    logic signed [WIDTH-1:0] ds;
    ds = signed'(d);
    case (md)
      MODE_SHR: shift_step = {sl, d[WIDTH-1:1]};
      MODE_SHL: shift_step = {d[WIDTH-2:0], sr};
      MODE_ROR: shift_step = {d[0], d[WIDTH-1:1]};
      MODE_ROL: shift_step = {d[WIDTH-2:0], d[WIDTH-1]};
      MODE_ASR: shift_step = unsigned'(ds >>> 1);
      default:  shift_step = d;
    endcase
  endfunction

  assign accept     = start && (state != RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign err        = err_q;
  assign sout_left  = d_out[WIDTH-1];
  assign sout_right = d_out[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      d_out  <= '0;
      mode_q <= MODE_LOAD;
      rem    <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
      if (mode == MODE_LOAD) begin
        d_out <= load_data;
        state <= DONE;
      end else if (mode[2] && mode[1]) begin
        err_q <= 1'b1;
        state <= DONE;
      end else if (count == '0) begin
        state <= DONE;
      end else begin
        mode_q <= mode;
        rem    <= count;
        state  <= RUN;
      end
    end else begin
      case (state)
        RUN: begin
          d_out <= shift_step(d_out, mode_q, sin_left, sin_right);
          rem   <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_reg_ctrl.sv
// Bench for universal_shift_reg_ctrl: directed scenarios plus random commands
// compared every cycle against a queue-based behavioural model.
module tb_universal_shift_reg_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] load_data;
  logic             sin_left;
  logic             sin_right;
  logic [WIDTH-1:0] d_out;
  logic             sout_left;
  logic             sout_right;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  // Model: register value, queue of pending single-bit ops, status flags
  int m_d;
  int m_ops[$];
  bit m_done;
  bit m_err;

  universal_shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count),
    .load_data(load_data), .sin_left(sin_left), .sin_right(sin_right),
    .d_out(d_out), .sout_left(sout_left), .sout_right(sout_right),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op1(input int d, input int md, input int sl, input int sr);
    case (md)
      1: return (d / 2) + sl * 128;
      2: return ((d * 2) % 256) + sr;
      3: return (d / 2) + (d % 2) * 128;
      4: return ((d * 2) % 256) + (d / 128);
      5: return (d / 2) + (d / 128) * 128;
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    m_d = 0;
    m_ops.delete();
    m_done = 0;
    m_err = 0;
  endtask

  task automatic model_edge();
    int md;
    m_done = 0;
    m_err = 0;
    if (m_ops.size() > 0) begin
      md = m_ops.pop_front();
      m_d = op1(m_d, md, int'(sin_left), int'(sin_right));
      m_done = (m_ops.size() == 0);
    end else if (start) begin
      if (mode == 3'd0) begin
        m_d = int'(load_data);
        m_done = 1;
      end else if (mode > 3'd5) begin
        m_done = 1;
        m_err = 1;
      end else if (count == '0) begin
        m_done = 1;
      end else begin
        for (int i = 0; i < int'(count); i++) m_ops.push_back(int'(mode));
      end
    end
  endtask

  task automatic check_all();
    chk("d_out", int'(d_out), m_d);
    chk("busy", int'(busy), int'(m_ops.size() > 0));
    chk("done", int'(done), int'(m_done));
    chk("err", int'(err), int'(m_err));
    chk("sout_left", int'(sout_left), (m_d / 128) % 2);
    chk("sout_right", int'(sout_right), m_d % 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic cmd(input logic [2:0] md, input logic [CNT_W-1:0] cnt, input logic [7:0] ld);
    start = 1'b1;
    mode = md;
    count = cnt;
    load_data = ld;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = '0;
    count = '0;
    load_data = '0;
    sin_left = 1'b0;
    sin_right = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Load then logical shift right with ones entering
    cmd(3'd0, 4'd0, 8'hA5);
    chk("load_a5", int'(d_out), 'hA5);
    sin_left = 1'b1;
    cmd(3'd1, 4'd3, 8'h00);
    chk("shr_k_unchanged", int'(d_out), 'hA5);
    step(); chk("shr_1", int'(d_out), 'hD2);
    step(); chk("shr_2", int'(d_out), 'hE9);
    step(); chk("shr_3", int'(d_out), 'hF4);
    chk("shr_done", int'(done), 1);
    step(); chk("shr_idle_busy", int'(busy), 0);
    sin_left = 1'b0;

    // Rotate left by 4 swaps nibbles
    cmd(3'd0, 4'd0, 8'hA5);
    cmd(3'd4, 4'd4, 8'h00);
    repeat (4) step();
    chk("rol4", int'(d_out), 'h5A);
    chk("rol4_err", int'(err), 0);
    step(); chk("rol4_done_single", int'(done), 0);

    // Shift left with zero entering
    sin_right = 1'b0;
    cmd(3'd0, 4'd0, 8'h81);
    cmd(3'd2, 4'd2, 8'h00);
    repeat (2) step();
    chk("shl2", int'(d_out), 'h04);

    // Arithmetic shift right replicates the sign bit
    cmd(3'd0, 4'd0, 8'h84);
    cmd(3'd5, 4'd2, 8'h00);
    step(); chk("asr_1", int'(d_out), 'hC2);
    step(); chk("asr_2", int'(d_out), 'hE1);
    step();

    // Zero count and illegal mode complete immediately
    cmd(3'd3, 4'd0, 8'h00);
    chk("cnt0_done", int'(done), 1);
    chk("cnt0_hold", int'(d_out), 'hE1);
    step();
    cmd(3'd6, 4'd5, 8'h11);
    chk("illegal_err", int'(err), 1);
    chk("illegal_hold", int'(d_out), 'hE1);
    step();
    chk("illegal_err_clear", int'(err), 0);

    // Start during RUN ignored; start held into DONE accepted
    sin_left = 1'b1;
    cmd(3'd1, 4'd5, 8'h00);
    step();
    cmd(3'd0, 4'd0, 8'hFF);
    repeat (3) step();
    chk("run_ignore_done", int'(done), 1);
    start = 1'b1; mode = 3'd4; count = 4'd3; load_data = 8'h00;
    step();
    chk("b2b_busy", int'(busy), 1);
    start = 1'b0;
    repeat (4) step();

    // Asynchronous reset mid-RUN
    cmd(3'd2, 4'd9, 8'h00);
    step();
    step();
    #2 rst = 1'b1;
    model_reset();
    #1 chk("arst_d", int'(d_out), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    cmd(3'd0, 4'd0, 8'h3C);
    chk("post_rst_load", int'(d_out), 'h3C);

    // Random commands every cycle
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      mode = 3'($urandom_range(0, 7));
      count = CNT_W'($urandom_range(0, 6));
      load_data = 8'($urandom);
      sin_left = 1'($urandom);
      sin_right = 1'($urandom);
      step();
    end
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
